mant_add_arbiter: RTL and testbench

- Shares one MatissaAdder48 instance (ports A, B, ct, out, bit range 55:8) between two requesters.
- Packs two narrow (19-bit) adds into one adder cycle using split mode (ct=1). Issues full 48-bit adds alone (ct=0).
- Sits between the multiplier's mantissa post-processing stages and the shared adder.
- Provides per-requester valid/ready handshakes and registered responses.

---
 rtl/mant_add_arbiter_if.sv | 24 ++
 rtl/mant_add_arbiter.sv | 115 +++++++++++
 tb/tb_mant_add_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mant_add_arbiter_if.sv
// Request/response bundle between the two mantissa requesters and the shared-adder arbiter.
interface mant_add_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wide;
  logic [47:0] req0_a;
  logic [47:0] req0_b;
  logic [47:0] req1_a;
  logic [47:0] req1_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [47:0] rsp0_sum;
  logic [47:0] rsp1_sum;

  modport master (
    output req_valid, req_wide, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp0_sum, rsp1_sum
  );

  modport slave (
    input  req_valid, req_wide, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp0_sum, rsp1_sum
  );
endinterface

// File: rtl/mant_add_arbiter.sv
// Shares one split-capable 48-bit mantissa adder between two requesters, packing two
// narrow adds into one adder cycle when possible.
module mant_add_arbiter #(
  parameter int W_NAR = 19,
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  mant_add_arbiter_if.slave bus,
  output logic [W_CNT-1:0] pair_cnt
);
  localparam int W_FULL = 48;
  localparam int W_RES  = W_NAR + 1;
  localparam int HI_LSB = W_FULL - 1 - W_NAR;
  localparam int GAP    = HI_LSB - W_NAR;

  logic [1:0]        busy;
  logic [1:0]        rsp_valid_r;
  logic              rr;
  logic              iss_valid;
  logic              iss_ct;
  logic              iss_wide;
  logic [1:0]        iss_owner;
  logic [W_FULL-1:0] iss_a, iss_b;
  logic [W_FULL-1:0] rsp0_r, rsp1_r;

  logic [1:0]        e, acc, drain;
  logic              pair, gnt;
  logic [W_FULL-1:0] op0_a, op0_b, op1_a, op1_b, nxt_a, nxt_b;

  // Adder view: internal bit k sits on adder port bit k+8.
  logic [55:8]       add_a, add_b, add_out;
  logic [20:0]       seg_lo;
  logic [27:0]       seg_hi;
  logic [W_FULL-1:0] sum_lo, sum_hi;

  function automatic logic [W_FULL-1:0] zext_nar(input logic [W_NAR-1:0] x);
    return {{(W_FULL-W_NAR){1'b0}}, x};
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc   = 2'b00;
    nxt_a = '0;
    nxt_b = '0;
    e     = bus.req_valid & ~busy;
    pair  = (&e) & ~(|bus.req_wide);
    gnt   = e[rr] ? rr : ~rr;
    drain = rsp_valid_r & bus.rsp_ready;
    op0_a = bus.req_wide[0] ? bus.req0_a : zext_nar(bus.req0_a[W_NAR-1:0]);
    op0_b = bus.req_wide[0] ? bus.req0_b : zext_nar(bus.req0_b[W_NAR-1:0]);
    op1_a = bus.req_wide[1] ? bus.req1_a : zext_nar(bus.req1_a[W_NAR-1:0]);
    op1_b = bus.req_wide[1] ? bus.req1_b : zext_nar(bus.req1_b[W_NAR-1:0]);
    if (pair) begin
      acc   = 2'b11;
      nxt_a = {1'b0, bus.req1_a[W_NAR-1:0], {GAP{1'b0}}, bus.req0_a[W_NAR-1:0]};
      nxt_b = {1'b0, bus.req1_b[W_NAR-1:0], {GAP{1'b0}}, bus.req0_b[W_NAR-1:0]};
    end else if (|e) begin
      acc   = gnt ? 2'b10 : 2'b01;
      nxt_a = gnt ? op1_a : op0_a;
      nxt_b = gnt ? op1_b : op0_b;
    end
  end

  // Split mode cuts the carry from segment [27:8] into [55:28].
  assign add_a   = iss_a;
  assign add_b   = iss_b;
  assign seg_lo  = {1'b0, add_a[27:8]} + {1'b0, add_b[27:8]};
  assign seg_hi  = add_a[55:28] + add_b[55:28] + {27'b0, seg_lo[20] & ~iss_ct};
  assign add_out = {seg_hi, seg_lo[19:0]};
  assign sum_lo  = {{(W_FULL-W_RES){1'b0}}, add_out[8 +: W_RES]};
  assign sum_hi  = {{(W_FULL-W_RES){1'b0}}, add_out[HI_LSB+8 +: W_RES]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 2'b00;
      rr          <= 1'b0;
      iss_valid   <= 1'b0;
      iss_ct      <= 1'b0;
      iss_wide    <= 1'b0;
      iss_owner   <= 2'b00;
      iss_a       <= '0;
      iss_b       <= '0;
      rsp_valid_r <= 2'b00;
      rsp0_r      <= '0;
      rsp1_r      <= '0;
      pair_cnt    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      busy      <= (busy | acc) & ~drain;
      iss_valid <= |acc;
      if (|acc) begin
        iss_a     <= nxt_a;
        iss_b     <= nxt_b;
        iss_ct    <= pair;
        iss_wide  <= pair ? 1'b0 : bus.req_wide[gnt];
        iss_owner <= acc;
      end
      if (pair && !(&pair_cnt))
        pair_cnt <= pair_cnt + {{(W_CNT-1){1'b0}}, 1'b1};
      if ((|acc) && !pair)
        rr <= ~gnt;
      rsp_valid_r <= (rsp_valid_r & ~drain) | (iss_valid ? iss_owner : 2'b00);
      if (iss_valid && iss_owner[0])
        rsp0_r <= iss_wide ? add_out : sum_lo;
      if (iss_valid && iss_owner[1])
        rsp1_r <= iss_ct ? sum_hi : (iss_wide ? add_out : sum_lo);
    end
  end

  assign bus.req_ready = ~busy;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp0_sum  = rsp0_r;
  assign bus.rsp1_sum  = rsp1_r;
endmodule

// File: tb/tb_mant_add_arbiter.sv
// Scoreboard bench for mant_add_arbiter: directed cases plus randomized traffic against a
// transaction-level model of arbitration and sums.
module tb_mant_add_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mant_add_arbiter_if bus();
  mant_add_arbiter_if sat_bus();

  logic [1:0]  v_valid, v_wide, r_ready;
  logic [47:0] a0, b0, a1, b1;
  logic [15:0] pair_cnt;
  logic [3:0]  pair_cnt_sat;

  assign bus.req_valid = v_valid;
  assign bus.req_wide  = v_wide;
  assign bus.req0_a    = a0;
  assign bus.req0_b    = b0;
  assign bus.req1_a    = a1;
  assign bus.req1_b    = b1;
  assign bus.rsp_ready = r_ready;
  assign sat_bus.req_valid = v_valid;
  assign sat_bus.req_wide  = v_wide;
  assign sat_bus.req0_a    = a0;
  assign sat_bus.req0_b    = b0;
  assign sat_bus.req1_a    = a1;
  assign sat_bus.req1_b    = b1;
  assign sat_bus.rsp_ready = r_ready;

  mant_add_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .pair_cnt(pair_cnt));
  // Narrow counter copy sees identical traffic so saturation is reachable quickly.
  mant_add_arbiter #(.W_CNT(4)) sat_dut (.clk(clk), .rst(rst), .bus(sat_bus), .pair_cnt(pair_cnt_sat));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] ref_sum(input logic wide, input logic [47:0] a, input logic [47:0] b);
    logic [19:0] n;
    if (wide) return a + b;
    n = 20'(a[18:0]) + 20'(b[18:0]);
    return {28'b0, n};
  endfunction

  typedef struct {
    int          owner;
    logic [47:0] sum;
    int          stamp;
  } exp_t;

  exp_t sb[$];
  int   now = 0;
  logic [1:0] busy_m = 2'b00;
  logic [1:0] seen   = 2'b00;
  logic       rr_m   = 1'b0;
  int         pc_m   = 0;

  function automatic int find(input int i);
    foreach (sb[k]) if (sb[k].owner == i) return k;
    return -1;
  endfunction

  task automatic push(input int i);
    exp_t x;
    x.owner = i;
    x.sum   = (i == 0) ? ref_sum(v_wide[0], a0, b0) : ref_sum(v_wide[1], a1, b1);
    x.stamp = now;
    sb.push_back(x);
  endtask

  // Monitor and reference model: samples on the falling edge, predicting the next rising edge.
  always @(negedge clk) begin
    logic [1:0]  e, acc, drain, rdy_exp;
    logic [47:0] sum;
    logic        g;
    int          idx;
    now++;
    if (rst) begin
      check("rst_req_ready", bus.req_ready, 2'b11);
      check("rst_rsp_valid", bus.rsp_valid, 2'b00);
      check("rst_pair_cnt", pair_cnt, 0);
      check("rst_sums", {bus.rsp0_sum[31:0], bus.rsp1_sum[31:0]}, 0);
      sb.delete();
      busy_m = 2'b00; seen = 2'b00; rr_m = 1'b0; pc_m = 0;
    end else begin
      rdy_exp = ~busy_m;
      check("req_ready", bus.req_ready, rdy_exp);
      check("pair_cnt", pair_cnt, (pc_m > 65535) ? 65535 : pc_m);
      check("pair_cnt_sat", pair_cnt_sat, (pc_m > 15) ? 15 : pc_m);
      drain = 2'b00;
      for (int i = 0; i < 2; i++) begin
        idx = find(i);
        sum = (i == 0) ? bus.rsp0_sum : bus.rsp1_sum;
        if (bus.rsp_valid[i]) begin
          if (idx < 0) begin
            check($sformatf("rsp%0d_unexpected", i), bus.rsp_valid[i], 1'b0);
          end else begin
            if (!seen[i]) begin
              check($sformatf("rsp%0d_latency", i), now - sb[idx].stamp, 2);
              check($sformatf("rsp%0d_sum", i), sum, sb[idx].sum);
              seen[i] = 1'b1;
            end
            if (r_ready[i]) begin
              check($sformatf("rsp%0d_sum_at_drain", i), sum, sb[idx].sum);
              sb.delete(idx);
              seen[i]  = 1'b0;
              drain[i] = 1'b1;
            end
          end
        end else if (idx >= 0 && !seen[i] && (now - sb[idx].stamp) > 2) begin
          check($sformatf("rsp%0d_late", i), 1'b0, 1'b1);
          seen[i] = 1'b1;
        end
      end
      e   = v_valid & ~busy_m;
      acc = 2'b00;
      if (e == 2'b11 && v_wide == 2'b00) begin
        push(0); push(1);
        acc = 2'b11;
        pc_m++;
      end else if (e != 2'b00) begin
        g = e[rr_m] ? rr_m : ~rr_m;
        push(int'(g));
        acc  = g ? 2'b10 : 2'b01;
        rr_m = ~g;
      end
      busy_m = (busy_m | acc) & ~drain;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the arbiter takes it (req_ready falls).
  task automatic drive(input int i, input logic wide, input logic [47:0] a, input logic [47:0] b);
    int t = 0;
    while (bus.req_ready[i] !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
    if (i == 0) begin a0 = a; b0 = b; end else begin a1 = a; b1 = b; end
    v_wide[i]  = wide;
    v_valid[i] = 1'b1;
    do begin @(posedge clk); #1; t++; end while (bus.req_ready[i] === 1'b1 && t < 300);
    v_valid[i] = 1'b0;
    check($sformatf("req%0d_accept_timeout", i), (t >= 300), 1'b0);
  endtask

  task automatic rand_drv(input int i, input int n);
    logic [47:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      b = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      drive(i, ($urandom_range(3) == 0), a, b);
      idle($urandom_range(2));
    end
  endtask

  bit rand_on = 1'b0;

  initial begin
    int t;
    rst = 1'b1; v_valid = 2'b00; v_wide = 2'b00; r_ready = 2'b11;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single wide add that wraps to zero.
    drive(0, 1'b1, 48'hFFFF_FFFF_FFFF, 48'h1);
    idle(4);

    // Packed pair; upper operand bits are junk and must be ignored.
    fork
      drive(0, 1'b0, {29'h15555555, 19'h7FFFF}, 48'h1);
      drive(1, 1'b0, {29'h0AAAAAAA, 19'h40000}, 48'h40000);
    join
    idle(4);

    // Contention: wide vs narrow, presented twice.
    for (int k = 0; k < 2; k++) begin
      fork
        drive(0, 1'b1, 48'h8000_0000_0001, 48'h7FFF_FFFF_FFFF);
        drive(1, 1'b0, 48'h3_FFFF, 48'h3_FFFF);
      join
      idle(4);
    end

    // Backpressure on requester 0 while requester 1 keeps flowing.
    r_ready[0] = 1'b0;
    drive(0, 1'b0, 48'h1_2345, 48'h5_4321);
    t = 0;
    while (bus.rsp_valid[0] !== 1'b1 && t < 20) begin idle(1); t++; end
    check("bp_rsp0_timeout", (t >= 20), 1'b0);
    fork
      begin idle(10); r_ready[0] = 1'b1; end
      begin
        drive(1, 1'b1, 48'h0000_FFFF_0000, 48'h0001_0001_0001);
        drive(1, 1'b0, 48'h7_FFFF, 48'h7_FFFF);
      end
    join
    idle(4);

    // Run enough pairs back to back to saturate the narrow counter copy.
    repeat (20) begin
      fork
        drive(0, 1'b0, 48'($urandom), 48'($urandom));
        drive(1, 1'b0, 48'($urandom), 48'($urandom));
      join
    end
    idle(4);

    // Randomized traffic with random response backpressure.
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(posedge clk); #1;
        r_ready = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      end
    join_none
    fork
      rand_drv(0, 120);
      rand_drv(1, 120);
    join
    rand_on = 1'b0;
    idle(1);
    r_ready = 2'b11;
    idle(8);

    // Reset the cycle after a pair accept: that pair must never respond.
    fork
      drive(0, 1'b0, 48'h1, 48'h2);
      drive(1, 1'b0, 48'h3, 48'h4);
    join
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(8);
    drive(1, 1'b0, 48'h7_0000, 48'h1_0000);
    idle(6);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end
endmodule
